// File: rtl/regfile_rat.sv
// regfile_rat: architectural register file with rename table, commit bypass and ROB forwarding
module regfile_rat #(
    parameter int rob_size = 16,
    parameter int rob_index_bits = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          load_reg_dec,
    input  logic [4:0]                    regidx_dec,
    input  logic [31:0]                   regdata_dec,
    input  logic                          load_reg_wb,
    input  logic [4:0]                    regidx_wb,
    input  logic [31:0]                   regdata_wb,
    input  logic [rob_index_bits-1:0]     rob_head,
    input  logic [rob_size-1:0]           done_rob,
    input  logic [rob_size-1:0][31:0]     data_rob,
    input  logic [4:0]                    rs1_idx,
    input  logic [4:0]                    rs2_idx,
    output logic                          rs1_ready,
    output logic                          rs2_ready,
    output logic [31:0]                   rs1_data,
    output logic [31:0]                   rs2_data,
    output logic [31:0]                   retired_count
);
    logic [31:0]               data [32];
    logic                      busy [32];
    logic [rob_index_bits-1:0] tag  [32];
    logic                      wb, dec, unused_dec;

    assign wb = load_reg_wb && regidx_wb != 5'd0;
    assign dec = load_reg_dec && regidx_dec != 5'd0;
    assign unused_dec = ^regdata_dec[31:rob_index_bits];

    // rename is applied after commit so a same-cycle rename of the same register wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                data[i] <= '0;
                busy[i] <= 1'b0;
                tag[i]  <= '0;
            end
            retired_count <= '0;
        end else begin
            if (wb) begin
                data[regidx_wb] <= regdata_wb;
                if (busy[regidx_wb] && tag[regidx_wb] == rob_head) busy[regidx_wb] <= 1'b0;
                retired_count <= retired_count + 32'd1;
            end
            if (dec) begin
                busy[regidx_dec] <= 1'b1;
                tag[regidx_dec]  <= regdata_dec[rob_index_bits-1:0];
            end
        end
    end

    function automatic logic [32:0] rd(input logic [4:0] i);
        logic [rob_index_bits-1:0] t;
        logic                      byp;
        t = tag[i];
        byp = load_reg_wb && regidx_wb == i && busy[i] && t == rob_head;
        return i == 5'd0 ? 33'h1_0000_0000 :
               byp       ? {1'b1, regdata_wb} :
               !busy[i]  ? {1'b1, data[i]} :
               done_rob[t] ? {1'b1, data_rob[t]} : {1'b0, 32'(t)};
    endfunction

    assign {rs1_ready, rs1_data} = rd(rs1_idx);
    assign {rs2_ready, rs2_data} = rd(rs2_idx);
endmodule

// File: doc/regfile_rat.md
# regfile_rat

Architectural register file merged with a register alias table (RAT) for the out-of-order core. It sits between decode and the reorder buffer. At decode it records which ROB entry will produce each destination register. At commit it takes the retired value from the ROB head. It gives the reservation stations either a ready operand value or the ROB tag to wait on, and forwards values the ROB already holds but has not yet retired.

## Interface
Parameters:
- rob_size, 16, number of ROB entries
- rob_index_bits, 4, ROB tag width (log2 rob_size)

Ports (clock and reset first):
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  reset, asynchronous and active-high
- load_reg_dec  in  1  rename strobe from decode
- regidx_dec  in  5  destination register being renamed
- regdata_dec  in  32  new ROB tag, zero-extended; only bits [rob_index_bits-1:0] are used
- load_reg_wb  in  1  commit strobe from the ROB head
- regidx_wb  in  5  register being committed
- regdata_wb  in  32  committed value
- rob_head  in  rob_index_bits  tag of the entry committing this cycle
- done_rob  in  rob_size  per-entry ROB result-valid bits
- data_rob  in  32 x rob_size  per-entry ROB results
- rs1_idx, rs2_idx  in  5 each  source register indices from decode
- rs1_ready, rs2_ready  out  1 each  1 when rsN_data holds the operand value
- rs1_data, rs2_data  out  32 each  operand value when ready; otherwise the zero-extended ROB tag
- retired_count  out  32  count of commits to a register other than x0

## Operation
State per register r (x1..x31):
- data[r], 32 bits
- busy[r], 1 bit
- tag[r], rob_index_bits

x0 is hardwired: its reads return ready=1 and data=0, and renames and commits to x0 are ignored.

Rename, when load_reg_dec=1 and regidx_dec!=0:
- busy[regidx_dec] <= 1
- tag[regidx_dec] <= regdata_dec[rob_index_bits-1:0]

Commit, when load_reg_wb=1 and regidx_wb!=0:
- data[regidx_wb] <= regdata_wb always.
- busy[regidx_wb] <= 0 only if busy=1 and tag[regidx_wb]==rob_head. Otherwise a younger rename still owns the register and busy/tag stay unchanged.
- retired_count increments by 1, wrapping modulo 2^32.

Rename and commit of the same register in the same cycle:
- Data is written.
- busy=1 and tag=new tag; the rename wins.

Read path, combinational, evaluated per source s with index i:
1. i==0: ready=1, data=0.
2. Else, if commit is active to i and busy[i] and tag[i]==rob_head: ready=1, data=regdata_wb (commit bypass).
3. Else, if busy[i]=0: ready=1, data=data[i].
4. Else, if done_rob[tag[i]]=1: ready=1, data=data_rob[tag[i]] (ROB forward).
5. Else: ready=0, data={0, tag[i]}.

A same-cycle rename never affects the read outputs. Sources always see the mapping from before the current instruction's own rename, so rd==rs1 is correct.

## Timing
- Read outputs are combinational from current state plus the inputs in the same cycle. There is no read latency.
- Rename and commit take effect at the next rising edge and are visible to reads in the following cycle.
- Reset (asserted at any time, including mid-operation) forces immediately, without waiting for a clock edge:
  - all data=0, busy=0, tag=0
  - retired_count=0
- Therefore, while rst=1: rs1_ready=rs2_ready=1 and rs1_data=rs2_data=0, provided no commit bypass or ROB forward applies. Busy=0 means neither can apply.
- Rename and commit strobes are ignored while rst=1.
- No handshake or backpressure: every asserted strobe is accepted in its cycle.
- Tag wrap-around: tags are compared with full rob_index_bits equality. The same tag value reissued after a ROB wrap is treated as the newest producer.

## Test plan
- Reset, then read x5 and x0 -> ready=1 and data=0 on both ports; retired_count=0.
- Rename x3 to tag 7 with done_rob[7]=0, then read x3 next cycle -> ready=0, data=7. Set done_rob[7]=1, data_rob[7]=0xDEADBEEF -> ready=1, data=0xDEADBEEF in the same cycle.
- Rename x3 to tag 2, then commit x3 with value 0x11 and rob_head=2 -> read in the commit cycle gives ready=1, data=0x11 (bypass). Next cycle busy=0, data[x3]=0x11, retired_count=1.
- Rename x4 to tag 1, then rename x4 to tag 5, then commit x4 with value 0x22 and rob_head=1 -> data[x4]=0x22, busy stays 1, a read of x4 gives ready=0, data=5.
- In the same cycle, rename x6 to tag 9 and read rs1_idx=6 (previously committed value 0x33) -> this cycle ready=1, data=0x33; next cycle ready=0, data=9.
- Rename x0 and commit x0 with value 0x55 -> x0 reads 0 and retired_count is unchanged. Assert rst mid-stream with x3 busy -> x3 reads ready=1, data=0 before the next clock edge.
